// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader.
//   boot_state_e : loader FSM states
//   MAGIC        : frame start byte
//   ACK / NAK    : response bytes returned to the host
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        RESP,
        RUN
    } boot_state_e;

    localparam logic [7:0] MAGIC = 8'hA5;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles little-endian payload bytes into 32-bit program words.
//   clk, n_reset : clock, asynchronous active-low reset
//   clear        : restart at byte lane 0 (pulsed on entry to payload phase)
//   byte_valid   : accept byte_data into the current lane
//   byte_data    : payload byte
//   last_lane    : current lane is lane 3 (next accepted byte completes a word)
//   word         : assembled word
//   word_valid   : one-cycle pulse the cycle after the 4th byte is accepted
module boot_word_packer (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_lane,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0] lane;

    assign last_lane = (lane == 2'd3);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            lane       <= 2'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane <= 2'd0;
            end else if (byte_valid) begin
                word[{lane, 3'b000} +: 8] <= byte_data;
                lane                      <= lane + 2'd1;
                word_valid                <= last_lane;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image, writes it into program
// memory, answers ACK/NAK and then releases the CPU, after which the UART is
// handed over to the CPU.
// Frame: A5, count_lo, count_hi, count*4 payload bytes (LE words), checksum.
//   clk, n_reset                         : clock, async active-low reset
//   rx_valid, rx_data                    : byte strobe from the UART receiver
//   tx_valid, tx_data, tx_ready          : byte handshake to the UART transmitter
//   cpu_rx_valid, cpu_rx_data            : received bytes forwarded to the CPU (RUN)
//   cpu_tx_valid, cpu_tx_data, cpu_tx_ready : CPU transmit handshake (RUN)
//   mem_we, mem_addr, mem_wdata          : program memory write port
//   cpu_reset                            : active-high CPU reset, low only in RUN
//   busy                                 : frame in progress (not IDLE / RUN)
//   dbg_state                            : current FSM state
// Handshake: a byte moves on tx in every cycle where tx_valid and tx_ready are
// both high; once raised by the loader, tx_valid and tx_data hold until then.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 10_000_000
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              cpu_rx_valid,
    output logic [7:0]        cpu_rx_data,
    input  logic              cpu_tx_valid,
    input  logic [7:0]        cpu_tx_data,
    output logic              cpu_tx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output boot_state_e       dbg_state
);

    localparam int          CNT_W     = $clog2(TIMEOUT + 1);
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    boot_state_e       state, next_state;
    logic [7:0]        len_lo;
    logic [15:0]       count;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        sum;
    logic [7:0]        resp_byte;
    logic [CNT_W-1:0]  to_cnt;

    logic [15:0] len_full;
    logic        len_ok;
    logic        data_entry;
    logic        timed;
    logic        to_expire;
    logic        pk_valid;
    logic        last_lane;
    logic        last_word;
    logic        run;

    assign len_full   = {rx_data, len_lo};
    assign len_ok     = (len_full != 16'd0) && (32'(len_full) <= MAX_WORDS);
    assign data_entry = (state == LEN_HI) && rx_valid && len_ok;
    assign pk_valid   = (state == DATA) && rx_valid;
    assign last_word  = (32'(addr) == (32'(count) - 32'd1));

    assign timed     = (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA)   || (state == CSUM);
    // Leave on the edge where the idle counter reaches TIMEOUT.
    assign to_expire = timed && !rx_valid && (to_cnt == CNT_W'(TIMEOUT - 1));

    boot_word_packer u_packer (
        .clk        (clk),
        .n_reset    (n_reset),
        .clear      (data_entry),
        .byte_valid (pk_valid),
        .byte_data  (rx_data),
        .last_lane  (last_lane),
        .word       (mem_wdata),
        .word_valid (mem_we)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (rx_valid && rx_data == MAGIC) next_state = LEN_LO;
            LEN_LO:  if (rx_valid) next_state = LEN_HI;
            LEN_HI:  if (rx_valid) next_state = len_ok ? DATA : RESP;
            DATA:    if (rx_valid && last_lane && last_word) next_state = CSUM;
            CSUM:    if (rx_valid) next_state = RESP;
            RESP:    if (tx_ready) next_state = (resp_byte == ACK) ? RUN : IDLE;
            RUN:     next_state = RUN;
            default: next_state = IDLE;
        endcase
        if (to_expire) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            len_lo    <= 8'd0;
            count     <= 16'd0;
            addr      <= '0;
            sum       <= 8'd0;
            resp_byte <= 8'd0;
            to_cnt    <= '0;
        end else begin
            if (!timed || rx_valid) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state == LEN_LO && rx_valid) begin
                len_lo <= rx_data;
            end
            if (state == LEN_HI && rx_valid) begin
                count <= len_full;
                if (!len_ok) begin
                    resp_byte <= NAK;
                end
            end

            if (data_entry) begin
                sum <= 8'd0;
            end else if (pk_valid) begin
                sum <= sum + rx_data;
            end

            // Address advances during the write pulse, so the pulse carries
            // the address of the word just assembled.
            if (data_entry) begin
                addr <= '0;
            end else if (mem_we) begin
                addr <= addr + 1'b1;
            end

            if (state == CSUM && rx_valid) begin
                resp_byte <= (rx_data == sum) ? ACK : NAK;
            end
        end
    end

    assign run          = (state == RUN);
    assign tx_valid     = run ? cpu_tx_valid : (state == RESP);
    assign tx_data      = run ? cpu_tx_data : resp_byte;
    assign cpu_tx_ready = run && tx_ready;
    assign cpu_rx_valid = run && rx_valid;
    assign cpu_rx_data  = rx_data;
    assign cpu_reset    = !run;
    assign busy         = (state != IDLE) && (state != RUN);
    assign mem_addr     = addr;
    assign dbg_state    = state;

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;
    import boot_pkg::*;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 100;
    localparam int WR_W    = ADDR_W + 32;

    logic              clk = 1'b0;
    logic              n_reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              cpu_rx_valid;
    logic [7:0]        cpu_rx_data;
    logic              cpu_tx_valid;
    logic [7:0]        cpu_tx_data;
    logic              cpu_tx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              busy;
    boot_state_e       dbg_state;

    uart_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .cpu_rx_valid (cpu_rx_valid),
        .cpu_rx_data  (cpu_rx_data),
        .cpu_tx_valid (cpu_tx_valid),
        .cpu_tx_data  (cpu_tx_data),
        .cpu_tx_ready (cpu_tx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    logic [WR_W-1:0] exp_q[$];
    logic [WR_W-1:0] got_wr_q[$];
    logic [7:0]      exp_tx_q[$];
    logic [7:0]      got_tx_q[$];
    logic [31:0]     words[$];
    bit              exp_run;

    // Observed memory writes and tx transfers, sampled mid-cycle.
    always @(negedge clk) begin
        if (n_reset === 1'b1) begin
            if (mem_we === 1'b1) got_wr_q.push_back({mem_addr, mem_wdata});
            if (tx_valid === 1'b1 && tx_ready === 1'b1) got_tx_q.push_back(tx_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_queues();
        int n;
        check("wr_count", 64'(got_wr_q.size()), 64'(exp_q.size()));
        n = (got_wr_q.size() < exp_q.size()) ? got_wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("wr_entry", 64'(got_wr_q[i]), 64'(exp_q[i]));
        check("tx_count", 64'(got_tx_q.size()), 64'(exp_tx_q.size()));
        n = (got_tx_q.size() < exp_tx_q.size()) ? got_tx_q.size() : exp_tx_q.size();
        for (int i = 0; i < n; i++) check("tx_byte", 64'(got_tx_q[i]), 64'(exp_tx_q[i]));
        exp_q.delete();
        got_wr_q.delete();
        exp_tx_q.delete();
        got_tx_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        n_reset      = 1'b0;
        rx_valid     = 1'b0;
        tx_ready     = 1'b0;
        cpu_tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        exp_q.delete();
        got_wr_q.delete();
        exp_tx_q.delete();
        got_tx_q.delete();
        exp_run = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        check("cpu_rx_gated", 64'(cpu_rx_valid), 64'(0));
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // Sends one frame built from words[] and records the expected outcome.
    task automatic send_frame(input int cnt, input bit bad, input int gap_max);
        logic [7:0] csum;
        logic [7:0] b;
        csum = 8'd0;
        send_byte(MAGIC, $urandom_range(0, gap_max));
        send_byte(8'(cnt), $urandom_range(0, gap_max));
        send_byte(8'(cnt >> 8), $urandom_range(0, gap_max));
        if (cnt >= 1 && cnt <= (1 << ADDR_W)) begin
            for (int i = 0; i < cnt; i++) begin
                for (int k = 0; k < 4; k++) begin
                    b    = 8'((words[i] >> (8 * k)) & 32'hFF);
                    csum = 8'((int'(csum) + int'(b)) % 256);
                    send_byte(b, $urandom_range(0, gap_max));
                end
                exp_q.push_back({ADDR_W'(i), words[i]});
            end
            if (bad) csum = csum + 8'($urandom_range(1, 255));
            send_byte(csum, 0);
            exp_tx_q.push_back(bad ? NAK : ACK);
            exp_run = !bad;
        end else begin
            exp_tx_q.push_back(NAK);
            exp_run = 1'b0;
        end
    endtask

    // Waits for the response, holds tx_ready low for a while, completes the
    // handshake and checks the resulting state and logged traffic.
    task automatic finish_frame(input int ready_delay);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("resp_valid", 64'(tx_valid), 64'(1));
        if (tx_valid === 1'b1) begin
            check("resp_byte", 64'(tx_data), 64'(exp_tx_q[$]));
            check("resp_cpu_reset", 64'(cpu_reset), 64'(1));
            check("resp_busy", 64'(busy), 64'(1));
            repeat (ready_delay) begin
                @(negedge clk);
                check("hold_valid", 64'(tx_valid), 64'(1));
                check("hold_data", 64'(tx_data), 64'(exp_tx_q[$]));
            end
            @(posedge clk);
            #1 tx_ready = 1'b1;
            @(posedge clk);
            #1 tx_ready = 1'b0;
        end
        @(negedge clk);
        check("post_busy", 64'(busy), 64'(0));
        check("post_cpu_reset", 64'(cpu_reset), 64'(!exp_run));
        check("post_state", 64'(dbg_state), 64'(exp_run ? RUN : IDLE));
        check("post_tx_valid", 64'(tx_valid), 64'(0));
        compare_queues();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        n_reset      = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'd0;
        tx_ready     = 1'b0;
        cpu_tx_valid = 1'b0;
        cpu_tx_data  = 8'd0;
        exp_run      = 1'b0;
        #12;
        check("rst_cpu_reset", 64'(cpu_reset), 64'(1));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_cpu_tx_ready", 64'(cpu_tx_ready), 64'(0));
        do_reset();

        // Bad checksum, then noise in IDLE, then the reference good frame.
        words = '{32'h11223344};
        send_frame(1, 1'b1, 2);
        finish_frame(0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'($urandom_range(0, 8'hA4)), 0);
        end
        check("noise_idle", 64'(busy), 64'(0));
        words = '{32'h11223344};
        send_frame(1, 1'b0, 2);
        finish_frame(0);
        do_reset();

        // Two words, delayed tx_ready, then CPU-owned UART.
        words = '{$urandom(), $urandom()};
        send_frame(2, 1'b0, 3);
        finish_frame(20);
        @(posedge clk);
        #1;
        cpu_tx_valid = 1'b1;
        cpu_tx_data  = 8'h55;
        @(negedge clk);
        check("run_tx_valid", 64'(tx_valid), 64'(1));
        check("run_tx_data", 64'(tx_data), 64'(8'h55));
        check("run_cpu_tx_ready_lo", 64'(cpu_tx_ready), 64'(0));
        @(posedge clk);
        #1 tx_ready = 1'b1;
        exp_tx_q.push_back(8'h55);
        @(negedge clk);
        check("run_cpu_tx_ready_hi", 64'(cpu_tx_ready), 64'(1));
        @(posedge clk);
        #1;
        cpu_tx_valid = 1'b0;
        tx_ready     = 1'b0;
        rx_valid     = 1'b1;
        rx_data      = 8'h3C;
        @(negedge clk);
        check("run_cpu_rx_valid", 64'(cpu_rx_valid), 64'(1));
        check("run_cpu_rx_data", 64'(cpu_rx_data), 64'(8'h3C));
        check("run_cpu_reset", 64'(cpu_reset), 64'(0));
        @(posedge clk);
        #1 rx_valid = 1'b0;
        compare_queues();
        do_reset();

        // Illegal counts; a magic byte arriving during RESP is dropped.
        words.delete();
        send_frame(0, 1'b0, 1);
        send_byte(MAGIC, 0);
        finish_frame(2);
        send_frame(513, 1'b0, 1);
        finish_frame(0);

        // Largest legal image fills every address.
        words.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) words.push_back($urandom());
        send_frame(1 << ADDR_W, 1'b1, 0);
        finish_frame(0);

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            int cnt;
            cnt = $urandom_range(1, 8);
            words.delete();
            for (int i = 0; i < cnt; i++) words.push_back($urandom());
            send_frame(cnt, 1'($urandom_range(0, 1)), 3);
            finish_frame($urandom_range(0, 5));
            if (exp_run) do_reset();
        end

        // Stall after two payload bytes.
        send_byte(MAGIC, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        repeat (95) @(negedge clk);
        check("to_busy_before", 64'(busy), 64'(1));
        repeat (10) @(negedge clk);
        check("to_busy_after", 64'(busy), 64'(0));
        check("to_state", 64'(dbg_state), 64'(IDLE));
        check("to_cpu_reset", 64'(cpu_reset), 64'(1));
        compare_queues();
        words = '{$urandom()};
        send_frame(1, 1'b1, 1);
        finish_frame(0);

        // Reset in the middle of the payload.
        send_byte(MAGIC, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(posedge clk);
        #1 n_reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        check("mid_rst_cpu_reset", 64'(cpu_reset), 64'(1));
        check("mid_rst_tx_valid", 64'(tx_valid), 64'(0));
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        repeat (30) @(negedge clk);
        compare_queues();
        words = '{$urandom(), $urandom(), $urandom()};
        send_frame(3, 1'b0, 2);
        finish_frame(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
